// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU encodings, FSM states and instruction field positions shared by the CPU blocks.
package cpu_pkg;
  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_BNE   = 8'd8;
  localparam logic [2:0] ALU_FWD = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam int OP_LSB   = 24;
  localparam int DST_LSB  = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;
  typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_HALT} state_e;
  typedef struct packed {
    logic       we;
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic       jump;
    logic       branch;
    logic       bne;
    logic       illegal;
  } dec_t;
endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: combinational opcode decode; opcode 8 is bne only when CPU_BNE_EN is defined.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] op_i,
  output dec_t       dec_o
);
  always_comb begin
    dec_o = '0;
    case (op_i)
      OP_LOADI: begin dec_o.we = 1'b1; dec_o.imm_sel = 1'b1; end
      OP_MOV:   dec_o.we = 1'b1;
      OP_ADD:   begin dec_o.we = 1'b1; dec_o.aluop = ALU_ADD; end
      OP_SUB:   begin dec_o.we = 1'b1; dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; end
      OP_AND:   begin dec_o.we = 1'b1; dec_o.aluop = ALU_AND; end
      OP_OR:    begin dec_o.we = 1'b1; dec_o.aluop = ALU_OR; end
      OP_J:     dec_o.jump = 1'b1;
      OP_BEQ:   begin dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; dec_o.branch = 1'b1; end
`ifdef CPU_BNE_EN
      OP_BNE:   begin dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; dec_o.branch = 1'b1; dec_o.bne = 1'b1; end
`endif
      default:  dec_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cpu_fetch_decode.sv
// cpu_fetch_decode: multi-cycle fetch/decode stage with PC, IR and branch resolution.
// Optional bne support via CPU_BNE_EN (handled in cpu_decoder).
module cpu_fetch_decode
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            IMEM_BUSY,
  input  logic            ZERO,
  output logic [PC_W-1:0] PC,
  output logic            IMEM_REQ,
  output logic [2:0]      READREG1,
  output logic [2:0]      READREG2,
  output logic [2:0]      WRITEREG,
  output logic            WRITEENABLE,
  output logic [7:0]      IMMEDIATE,
  output logic [2:0]      ALUOP,
  output logic            IMM_SEL,
  output logic            NEG_SEL,
  output logic            HALTED
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_seq, pc_tgt;
  logic [31:0]     ir_q, ir_d;
  logic [7:0]      off;
  dec_t            dec;
  cpu_decoder u_dec (.op_i(ir_q[OP_LSB +: 8]), .dec_o(dec));
  assign off    = ir_q[DST_LSB +: 8];
  assign pc_seq = pc_q + PC_W'(4);
  assign pc_tgt = pc_seq + {{(PC_W-10){off[7]}}, off, 2'b00};
  assign PC     = pc_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end
  // Outputs decode from state so an async reset clears them without an edge.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    IMEM_REQ    = 1'b0;
    READREG1    = '0;
    READREG2    = '0;
    WRITEREG    = '0;
    WRITEENABLE = 1'b0;
    IMMEDIATE   = '0;
    ALUOP       = ALU_FWD;
    IMM_SEL     = 1'b0;
    NEG_SEL     = 1'b0;
    HALTED      = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (!IMEM_BUSY) begin
          ir_d    = INSTRUCTION;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        READREG1    = ir_q[SRC1_LSB +: 3];
        READREG2    = ir_q[SRC2_LSB +: 3];
        WRITEREG    = ir_q[DST_LSB +: 3];
        IMMEDIATE   = ir_q[SRC2_LSB +: 8];
        WRITEENABLE = dec.we;
        ALUOP       = dec.aluop;
        IMM_SEL     = dec.imm_sel;
        NEG_SEL     = dec.neg_sel;
        state_d     = dec.illegal ? S_HALT : S_FETCH;
        pc_d        = dec.illegal ? pc_q :
                      (dec.jump | (dec.branch & (ZERO ^ dec.bne))) ? pc_tgt : pc_seq;
      end
      default: HALTED = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_cpu_fetch_decode.sv
// tb_cpu_fetch_decode: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_cpu_fetch_decode;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] INSTRUCTION = '0;
  logic        IMEM_BUSY = 1'b0;
  logic        ZERO = 1'b0;
  logic [31:0] PC;
  logic        IMEM_REQ, WRITEENABLE, IMM_SEL, NEG_SEL, HALTED;
  logic [2:0]  READREG1, READREG2, WRITEREG, ALUOP;
  logic [7:0]  IMMEDIATE;
  int checks = 0;
  int errors = 0;
  logic en = 1'b0;

  cpu_fetch_decode dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_BUSY(IMEM_BUSY), .ZERO(ZERO),
    .PC(PC), .IMEM_REQ(IMEM_REQ), .READREG1(READREG1), .READREG2(READREG2), .WRITEREG(WRITEREG),
    .WRITEENABLE(WRITEENABLE), .IMMEDIATE(IMMEDIATE), .ALUOP(ALUOP), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  function automatic logic legal(input logic [7:0] op);
`ifdef CPU_BNE_EN
    return op <= 8'd8;
`else
    return op <= 8'd7;
`endif
  endfunction

  function automatic logic [2:0] aluf(input logic [7:0] op);
    if (op == 2 || op == 3 || op == 7 || op == 8) return 3'd1;
    if (op == 4) return 3'd2;
    if (op == 5) return 3'd3;
    return 3'd0;
  endfunction

  function automatic logic taken(input logic [7:0] op, input logic z);
    return op == 6 || (op == 7 && z) || (op == 8 && !z);
  endfunction

  // phase: 0 reset, 1 fetch, 2 exec, 3 halt
  int          m_ph = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ir = '0;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_ph <= 0; m_pc <= '0; m_ir <= '0;
    end else if (m_ph == 0) m_ph <= 1;
    else if (m_ph == 1) begin
      if (!IMEM_BUSY) begin m_ir <= INSTRUCTION; m_ph <= 2; end
    end else if (m_ph == 2) begin
      if (!legal(m_ir[31:24])) m_ph <= 3;
      else begin
        m_ph <= 1;
        m_pc <= m_pc + 32'd4 + (taken(m_ir[31:24], ZERO) ? 32'($signed(m_ir[23:16])) * 32'd4 : 32'd0);
      end
    end
  end

  always @(negedge CLK) begin : cmp
    logic [24:0] e, a;
    logic [7:0]  op;
    logic        lg;
    if (en) begin
      op = m_ir[31:24];
      lg = legal(op);
      e = '0;
      e[24] = (m_ph == 1);
      e[23] = (m_ph == 3);
      if (m_ph == 2)
        e[22:0] = {m_ir[10:8], m_ir[2:0], m_ir[18:16], lg && op <= 5, m_ir[7:0],
                   lg ? aluf(op) : 3'd0, op == 0, lg && (op == 3 || op >= 7)};
      a = {IMEM_REQ, HALTED, READREG1, READREG2, WRITEREG, WRITEENABLE, IMMEDIATE, ALUOP, IMM_SEL, NEG_SEL};
      checks += 2;
      if (a !== e) begin errors++; $display("FAIL model_outputs t=%0t got %h want %h", $time, a, e); end
      if (PC !== m_pc) begin errors++; $display("FAIL model_pc t=%0t got %h want %h", $time, PC, m_pc); end
    end
  end

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %h want %h", n, act, exp); end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic z);
    INSTRUCTION = ins; ZERO = z; tick(); tick();
  endtask

  initial begin
    #1 RESET = 1'b0;
    #1 en = 1'b1;
    tick(); tick();
    lit("rst_pc", PC, 32'h0);
    lit("rst_we", {31'd0, WRITEENABLE}, 32'd0);
    lit("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    lit("rst_halt", {31'd0, HALTED}, 32'd0);
    INSTRUCTION = 32'h0002005F; RESET = 1'b1;
    tick();
    lit("fetch_req", {31'd0, IMEM_REQ}, 32'd1);
    tick();
    lit("loadi_wr", {29'd0, WRITEREG}, 32'd2);
    lit("loadi_imm", {24'd0, IMMEDIATE}, 32'h5F);
    lit("loadi_isel", {31'd0, IMM_SEL}, 32'd1);
    lit("loadi_we", {31'd0, WRITEENABLE}, 32'd1);
    IMEM_BUSY = 1'b1; INSTRUCTION = 32'h09000000;
    tick();
    lit("loadi_we_drop", {31'd0, WRITEENABLE}, 32'd0);
    lit("loadi_pc", PC, 32'd4);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) INSTRUCTION = 32'h03010203;
      tick();
      lit("busy_pc", PC, 32'd4);
      lit("busy_req", {31'd0, IMEM_REQ}, 32'd1);
    end
    IMEM_BUSY = 1'b0;
    tick();
    lit("sub_rr1", {29'd0, READREG1}, 32'd2);
    lit("sub_rr2", {29'd0, READREG2}, 32'd3);
    lit("sub_wr", {29'd0, WRITEREG}, 32'd1);
    lit("sub_alu", {29'd0, ALUOP}, 32'd1);
    lit("sub_neg", {31'd0, NEG_SEL}, 32'd1);
    tick();
    lit("sub_pc", PC, 32'd8);
    step(32'h06FE0000, 1'b0); lit("j_back", PC, 32'd4);
    step(32'h01010200, 1'b0); lit("mov_pc", PC, 32'd8);
    step(32'h07020000, 1'b1); lit("beq_taken", PC, 32'd20);
    step(32'h06FC0000, 1'b0); lit("j_to8", PC, 32'd8);
    step(32'h07020000, 1'b0); lit("beq_not", PC, 32'd12);
    step(32'h06800000, 1'b0); lit("j_wrap_down", PC, 32'hFFFFFE10);
    step(32'h067B0000, 1'b0); lit("j_wrap_up", PC, 32'h0);
    step(32'h01010200, 1'b0);
    INSTRUCTION = 32'h02030102;
    tick();
    lit("add_we", {31'd0, WRITEENABLE}, 32'd1);
    lit("add_alu", {29'd0, ALUOP}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    lit("async_we", {31'd0, WRITEENABLE}, 32'd0);
    lit("async_pc", PC, 32'd0);
    lit("async_wr", {29'd0, WRITEREG}, 32'd0);
    tick(); RESET = 1'b1; tick();
    step(32'h01010200, 1'b0);
    INSTRUCTION = 32'h09000000;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      lit("halt_flag", {31'd0, HALTED}, 32'd1);
      lit("halt_pc", PC, 32'd4);
      lit("halt_we", {31'd0, WRITEENABLE}, 32'd0);
      tick();
    end
    RESET = 1'b0;
    #1 lit("halt_clear", {31'd0, HALTED}, 32'd0);
    tick(); RESET = 1'b1; tick();
    step(32'h01010200, 1'b0);
    INSTRUCTION = 32'h08000000;
    tick(); tick();
`ifdef CPU_BNE_EN
    lit("bne_pc", PC, 32'd8);
`else
    lit("op8_halt", {31'd0, HALTED}, 32'd1);
    lit("op8_pc", PC, 32'd4);
`endif
    tick(); tick();
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
